// File: rtl/tcdm_atomic_pkg.sv
// Shared types for the TCDM atomic adapter.
//   amo_op_t    : request opcode carried on in_amo_i
//   amo_state_e : AMO read-modify-write sequencer states
//   rsv_slot_t  : one LR reservation entry, sized for the widest supported
//                 core id / word address; narrower values are zero-extended
package tcdm_atomic_pkg;

    typedef enum logic [3:0] {
        AMO_NONE = 4'h0,
        AMO_SWAP = 4'h1,
        AMO_ADD  = 4'h2,
        AMO_AND  = 4'h3,
        AMO_OR   = 4'h4,
        AMO_XOR  = 4'h5,
        AMO_MAX  = 4'h6,
        AMO_MAXU = 4'h7,
        AMO_MIN  = 4'h8,
        AMO_MINU = 4'h9,
        AMO_LR   = 4'hA,
        AMO_SC   = 4'hB
    } amo_op_t;

    typedef enum logic [1:0] {
        AmoIdle,
        AmoDo,
        AmoWriteBack
    } amo_state_e;

    localparam int unsigned RsvMaxCoreIdWidth = 32;
    localparam int unsigned RsvMaxAddrWidth   = 64;

    typedef struct packed {
        logic                         valid;
        logic [RsvMaxCoreIdWidth-1:0] core_id;
        logic [RsvMaxAddrWidth-1:0]   addr;
    } rsv_slot_t;

    // Unassigned codes C-F behave as a plain load/store.
    function automatic amo_op_t decode_amo(input logic [3:0] raw);
        return (raw > 4'hB) ? AMO_NONE : amo_op_t'(raw);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Common-cells style FIFO.
//   clk_i/rst_ni : clock, async active-low reset
//   flush_i      : drop all content
//   testmode_i   : unused here, kept for interface compatibility
//   full_o/empty_o/usage_o : status (usage wraps to 0 when full for 2^n depths)
//   data_i/push_i, data_o/pop_i : write and read ports
// With FALL_THROUGH set, a push into an empty FIFO is visible on data_o in
// the same cycle.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);
    localparam int unsigned FifoDepth = (DEPTH > 0) ? DEPTH : 1;

    dtype                  mem_q [FifoDepth];
    dtype                  mem_d [FifoDepth];
    logic [ADDR_DEPTH-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;
    assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(FifoDepth));
    assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];

    always_comb begin
        mem_d  = mem_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        data_o = mem_q[rd_q];
        if (push_i && !full_o) begin
            mem_d[wr_q] = data_i;
            wr_d        = (wr_q == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : wr_q + 1'b1;
            cnt_d       = cnt_q + 1'b1;
        end
        if (pop_i && !empty_o) begin
            rd_d  = (rd_q == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : rd_q + 1'b1;
            cnt_d = cnt_d - 1'b1;
        end
        // Bypass: an empty FIFO hands the pushed word straight through; if it
        // is consumed in the same cycle nothing is retained.
        if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                rd_d  = rd_q;
                wr_d  = wr_q;
                cnt_d = cnt_q;
            end
        end
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(FifoDepth); i++) mem_q[i] <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/lrsc_rsv_table.sv
// LR/SC reservation table.
//   set_i/set_core_i/set_addr_i : LR places a reservation for a core
//   clr_i/clr_core_i            : SC drops the requesting core's reservation
//   inv_i/inv_addr_i            : any SRAM write kills reservations on that word
//   chk_core_i/chk_addr_i/match_o : SC success lookup (current state)
// Within a cycle the invalidate and clear are applied before the set, so an
// LR racing a write to the same word keeps its fresh reservation.
module lrsc_rsv_table
    import tcdm_atomic_pkg::*;
#(
    parameter int unsigned NumRsv        = 4,
    parameter int unsigned CoreIdWidth   = 8,
    parameter int unsigned WordAddrWidth = 30
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     set_i,
    input  logic [CoreIdWidth-1:0]   set_core_i,
    input  logic [WordAddrWidth-1:0] set_addr_i,
    input  logic                     clr_i,
    input  logic [CoreIdWidth-1:0]   clr_core_i,
    input  logic                     inv_i,
    input  logic [WordAddrWidth-1:0] inv_addr_i,
    input  logic [CoreIdWidth-1:0]   chk_core_i,
    input  logic [WordAddrWidth-1:0] chk_addr_i,
    output logic                     match_o
);
    localparam int unsigned PtrW = (NumRsv > 1) ? $clog2(NumRsv) : 1;

    rsv_slot_t [NumRsv-1:0] slot_q, slot_d;
    logic [PtrW-1:0]        victim_q, victim_d;
    logic [PtrW-1:0]        idx;
    logic                   found;

    always_comb begin
        slot_d   = slot_q;
        victim_d = victim_q;
        idx      = victim_q;
        found    = 1'b0;
        for (int i = 0; i < int'(NumRsv); i++) begin
            if (inv_i && slot_d[i].valid &&
                slot_d[i].addr == RsvMaxAddrWidth'(inv_addr_i)) slot_d[i].valid = 1'b0;
            if (clr_i && slot_d[i].valid &&
                slot_d[i].core_id == RsvMaxCoreIdWidth'(clr_core_i)) slot_d[i].valid = 1'b0;
        end
        if (set_i) begin
            // Priority: the core's own slot, then the lowest free slot,
            // then round-robin eviction.
            for (int i = 0; i < int'(NumRsv); i++) begin
                if (!found && slot_d[i].valid &&
                    slot_d[i].core_id == RsvMaxCoreIdWidth'(set_core_i)) begin
                    idx   = PtrW'(i);
                    found = 1'b1;
                end
            end
            for (int i = 0; i < int'(NumRsv); i++) begin
                if (!found && !slot_d[i].valid) begin
                    idx   = PtrW'(i);
                    found = 1'b1;
                end
            end
            if (!found) begin
                victim_d = (victim_q == PtrW'(NumRsv - 1)) ? '0 : victim_q + 1'b1;
            end
            slot_d[idx].valid   = 1'b1;
            slot_d[idx].core_id = RsvMaxCoreIdWidth'(set_core_i);
            slot_d[idx].addr    = RsvMaxAddrWidth'(set_addr_i);
        end
    end

    always_comb begin
        match_o = 1'b0;
        for (int i = 0; i < int'(NumRsv); i++) begin
            if (slot_q[i].valid &&
                slot_q[i].core_id == RsvMaxCoreIdWidth'(chk_core_i) &&
                slot_q[i].addr == RsvMaxAddrWidth'(chk_addr_i)) match_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q   <= '0;
            victim_q <= '0;
        end else begin
            slot_q   <= slot_d;
            victim_q <= victim_d;
        end
    end

endmodule

// File: rtl/tcdm_atomic_adapter.sv
// Adds LR/SC and AMO support in front of a single-port SRAM with 1-cycle
// read latency.
//   in_*  request side : valid/ready, address, amo op, write, wdata, be, meta,
//                        core id
//   in_*  response side: valid/ready, rdata, meta (in acceptance order)
//   out_* SRAM side    : req, write, address, wdata, be, rdata (next cycle)
// Every responding request goes through a one-cycle stage so reads, SC
// results and AMO old values all enter the response FIFO in order.
module tcdm_atomic_adapter
    import tcdm_atomic_pkg::*;
#(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter type         metadata_t  = logic,
    parameter int unsigned CoreIdWidth = 8,
    parameter int unsigned NumRsv      = 4,
    parameter int unsigned RespDepth   = 2,
    parameter bit          RegisterAmo = 1'b0,
    localparam int unsigned BeWidth    = DataWidth / 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [AddrWidth-1:0]   in_address_i,
    input  logic [3:0]             in_amo_i,
    input  logic                   in_write_i,
    input  logic [DataWidth-1:0]   in_wdata_i,
    input  logic [BeWidth-1:0]     in_be_i,
    input  metadata_t              in_meta_i,
    input  logic [CoreIdWidth-1:0] in_core_id_i,
    output logic                   in_valid_o,
    input  logic                   in_ready_i,
    output logic [DataWidth-1:0]   in_rdata_o,
    output metadata_t              in_meta_o,
    output logic                   out_req_o,
    output logic                   out_write_o,
    output logic [AddrWidth-1:0]   out_add_o,
    output logic [DataWidth-1:0]   out_wdata_o,
    output logic [BeWidth-1:0]     out_be_o,
    input  logic [DataWidth-1:0]   out_rdata_i
);
    localparam int unsigned OffW      = $clog2(BeWidth);
    localparam int unsigned WordW     = AddrWidth - OffW;
    localparam int unsigned FifoAddrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        metadata_t            meta;
    } resp_t;

    amo_state_e           state_q, state_d;
    amo_op_t              op_q, op_d, in_op;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] operand_q, operand_d, result_q, result_d;
    logic                 rsp_vld_q, rsp_vld_d, rsp_sc_q, rsp_sc_d, rsp_fail_q, rsp_fail_d;
    metadata_t            rsp_meta_q, rsp_meta_d;

    logic                 acc, is_store, is_load, is_lr, is_sc, is_amo, sc_ok;
    logic [WordW-1:0]     in_word;
    logic                 rsv_set, rsv_clr, rsv_inv;
    logic [WordW-1:0]     rsv_inv_addr;
    logic [31:0]          occ;

    resp_t                fifo_in, fifo_out;
    logic                 fifo_full, fifo_empty;
    logic [FifoAddrW-1:0] fifo_usage;

    // mem < opnd via a (DataWidth+1)-bit subtract; signed ops sign-extend.
    function automatic logic [DataWidth-1:0] amo_alu(input amo_op_t op,
                                                     input logic [DataWidth-1:0] mem,
                                                     input logic [DataWidth-1:0] opnd);
        logic [DataWidth:0] sub;
        logic               sgn, lt;
        sgn = (op == AMO_MAX) || (op == AMO_MIN);
        sub = {sgn & mem[DataWidth-1], mem} - {sgn & opnd[DataWidth-1], opnd};
        lt  = sub[DataWidth];
        case (op)
            AMO_SWAP:           return opnd;
            AMO_ADD:            return mem + opnd;
            AMO_AND:            return mem & opnd;
            AMO_OR:             return mem | opnd;
            AMO_XOR:            return mem ^ opnd;
            AMO_MAX, AMO_MAXU:  return lt ? opnd : mem;
            AMO_MIN, AMO_MINU:  return lt ? mem : opnd;
            default:            return mem;
        endcase
    endfunction

    // Conservative: space is reserved for a response whether or not the
    // incoming request will produce one.
    always_comb begin
        occ        = fifo_full ? RespDepth : 32'(fifo_usage);
        in_ready_o = (state_q == AmoIdle) && ((occ + 32'(rsp_vld_q)) < RespDepth);
    end

    assign in_op    = decode_amo(in_amo_i);
    assign in_word  = in_address_i[AddrWidth-1:OffW];
    // rst_ni gating keeps the SRAM port quiet while reset is held.
    assign acc      = in_valid_i && in_ready_o && rst_ni;
    assign is_store = (in_op == AMO_NONE) && in_write_i;
    assign is_load  = (in_op == AMO_NONE) && !in_write_i;
    assign is_lr    = (in_op == AMO_LR);
    assign is_sc    = (in_op == AMO_SC);
    assign is_amo   = (in_op >= AMO_SWAP) && (in_op <= AMO_MINU);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        operand_d    = operand_q;
        result_d     = result_q;
        rsp_vld_d    = 1'b0;
        rsp_sc_d     = 1'b0;
        rsp_fail_d   = 1'b0;
        rsp_meta_d   = rsp_meta_q;
        out_req_o    = 1'b0;
        out_write_o  = 1'b0;
        out_add_o    = '0;
        out_wdata_o  = '0;
        out_be_o     = '0;
        rsv_set      = 1'b0;
        rsv_clr      = 1'b0;
        rsv_inv      = 1'b0;
        rsv_inv_addr = '0;
        case (state_q)
            AmoIdle: begin
                if (acc) begin
                    if (is_store || is_load || is_lr || is_amo || (is_sc && sc_ok)) begin
                        out_req_o   = 1'b1;
                        out_write_o = is_store || is_sc;
                        out_add_o   = in_address_i;
                        out_wdata_o = (is_store || is_sc) ? in_wdata_i : '0;
                        out_be_o    = is_amo ? '1 : in_be_i;
                    end
                    rsv_set    = is_lr;
                    rsv_clr    = is_sc;
                    rsp_vld_d  = !is_store;
                    rsp_sc_d   = is_sc;
                    rsp_fail_d = !sc_ok;
                    rsp_meta_d = in_meta_i;
                    if (is_amo) begin
                        state_d   = AmoDo;
                        op_d      = in_op;
                        addr_d    = in_address_i;
                        operand_d = in_wdata_i;
                    end
                end
            end
            AmoDo: begin
                if (RegisterAmo) begin
                    result_d = amo_alu(op_q, out_rdata_i, operand_q);
                    state_d  = AmoWriteBack;
                end else begin
                    out_req_o   = 1'b1;
                    out_write_o = 1'b1;
                    out_add_o   = addr_q;
                    out_wdata_o = amo_alu(op_q, out_rdata_i, operand_q);
                    out_be_o    = '1;
                    state_d     = AmoIdle;
                end
            end
            AmoWriteBack: begin
                out_req_o   = 1'b1;
                out_write_o = 1'b1;
                out_add_o   = addr_q;
                out_wdata_o = result_q;
                out_be_o    = '1;
                state_d     = AmoIdle;
            end
            default: state_d = AmoIdle;
        endcase
        if (out_req_o && out_write_o) begin
            rsv_inv      = 1'b1;
            rsv_inv_addr = out_add_o[AddrWidth-1:OffW];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= AmoIdle;
            op_q       <= AMO_NONE;
            addr_q     <= '0;
            operand_q  <= '0;
            result_q   <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_sc_q   <= 1'b0;
            rsp_fail_q <= 1'b0;
            rsp_meta_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            operand_q  <= operand_d;
            result_q   <= result_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_sc_q   <= rsp_sc_d;
            rsp_fail_q <= rsp_fail_d;
            rsp_meta_q <= rsp_meta_d;
        end
    end

    lrsc_rsv_table #(
        .NumRsv       (NumRsv),
        .CoreIdWidth  (CoreIdWidth),
        .WordAddrWidth(WordW)
    ) i_rsv_table (
        .clk_i,
        .rst_ni,
        .set_i      (rsv_set),
        .set_core_i (in_core_id_i),
        .set_addr_i (in_word),
        .clr_i      (rsv_clr),
        .clr_core_i (in_core_id_i),
        .inv_i      (rsv_inv),
        .inv_addr_i (rsv_inv_addr),
        .chk_core_i (in_core_id_i),
        .chk_addr_i (in_word),
        .match_o    (sc_ok)
    );

    // SC results replace the SRAM read data (0 = success, 1 = failure).
    assign fifo_in.data = rsp_sc_q ? DataWidth'(rsp_fail_q) : out_rdata_i;
    assign fifo_in.meta = rsp_meta_q;

    fifo_v3 #(
        .FALL_THROUGH(1'b1),
        .DEPTH       (RespDepth),
        .dtype       (resp_t)
    ) i_resp_fifo (
        .clk_i,
        .rst_ni,
        .flush_i   (1'b0),
        .testmode_i(1'b0),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .usage_o   (fifo_usage),
        .data_i    (fifo_in),
        .push_i    (rsp_vld_q),
        .data_o    (fifo_out),
        .pop_i     (in_ready_i && !fifo_empty)
    );

    assign in_valid_o = !fifo_empty;
    assign in_rdata_o = fifo_out.data;
    assign in_meta_o  = fifo_out.meta;

endmodule

// File: tb/tb_tcdm_atomic_adapter.sv
// Directed bench for tcdm_atomic_adapter (DataWidth=64, NumRsv=2,
// RespDepth=2, RegisterAmo=1) with a behavioural SRAM and a response
// scoreboard.
module tb_tcdm_atomic_adapter;
    import tcdm_atomic_pkg::*;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  m;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        in_valid_i, in_ready_o, in_write_i, in_valid_o, in_ready_i;
    logic [31:0] in_address_i;
    logic [3:0]  in_amo_i;
    logic [63:0] in_wdata_i, in_rdata_o, out_wdata_o, out_rdata_i;
    logic [7:0]  in_be_i, out_be_o, in_meta_i, in_meta_o, in_core_id_i;
    logic        out_req_o, out_write_o;
    logic [31:0] out_add_o;

    logic [63:0] mem [256];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [63:0] pl_val;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tcdm_atomic_adapter #(
        .AddrWidth(32), .DataWidth(64), .metadata_t(logic [7:0]), .CoreIdWidth(8),
        .NumRsv(2), .RespDepth(2), .RegisterAmo(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_address_i(in_address_i),
        .in_amo_i(in_amo_i), .in_write_i(in_write_i), .in_wdata_i(in_wdata_i),
        .in_be_i(in_be_i), .in_meta_i(in_meta_i), .in_core_id_i(in_core_id_i),
        .in_valid_o(in_valid_o), .in_ready_i(in_ready_i), .in_rdata_o(in_rdata_o),
        .in_meta_o(in_meta_o), .out_req_o(out_req_o), .out_write_o(out_write_o),
        .out_add_o(out_add_o), .out_wdata_o(out_wdata_o), .out_be_o(out_be_o),
        .out_rdata_i(out_rdata_i)
    );

    // Behavioural SRAM, 1-cycle read latency, word index = byte address >> 3.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (out_req_o) begin
            if (out_write_o) begin
                for (int b = 0; b < 8; b++)
                    if (out_be_o[b]) mem[out_add_o[10:3]][8*b +: 8] <= out_wdata_o[8*b +: 8];
            end else begin
                out_rdata_i <= mem[out_add_o[10:3]];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare every handshaken response against the queue head.
    always @(negedge clk) begin
        if (rst_ni && in_valid_o && in_ready_i) begin
            exp_t e;
            chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_data", in_rdata_o, e.d);
                chk("rsp_meta", 64'(in_meta_o), 64'(e.m));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [7:0] idx, input logic [63:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] m);
        exp_t e;
        e.d = d; e.m = m;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [31:0] a, input amo_op_t op, input logic w,
                         input logic [63:0] d, input logic [7:0] core, input logic [7:0] meta);
        in_valid_i = 1'b1; in_address_i = a; in_amo_i = op; in_write_i = w;
        in_wdata_i = d; in_be_i = '1; in_core_id_i = core; in_meta_i = meta;
    endtask

    // Offer a request, wait (bounded) for acceptance; returns at posedge+1.
    task automatic send(input logic [31:0] a, input amo_op_t op, input logic w,
                        input logic [63:0] d, input logic [7:0] core, input logic [7:0] meta);
        bit ok;
        ok = 1'b0;
        drive(a, op, w, d, core, meta);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready_o) begin ok = 1'b1; break; end
        end
        chk("accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready_o && !in_valid_o && sb.size() == 0) begin ok = 1'b1; break; end
        end
        chk(tag, 64'(ok), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        bit ok;
        rst_ni = 1'b0; in_ready_i = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        drive(32'h40, AMO_NONE, 1'b0, '0, 8'd0, 8'd0);
        // Reset: outputs held quiet even with a request offered.
        @(negedge clk);
        chk("rst_ready", 64'(in_ready_o), 64'd1);
        chk("rst_valid", 64'(in_valid_o), 64'd0);
        chk("rst_req", 64'(out_req_o), 64'd0);
        chk("rst_write", 64'(out_write_o), 64'd0);
        chk("rst_rdata", in_rdata_o, 64'd0);
        in_valid_i = 1'b0;
        @(posedge clk); #1;
        preload(8'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        preload(8'd8, 64'h1234);
        preload(8'h20, 64'h100); preload(8'h21, 64'h200); preload(8'h22, 64'h300);
        preload(8'd4, 64'd3);
        preload(8'd10, 64'hA1); preload(8'd11, 64'hB2); preload(8'd12, 64'hC3);
        preload(8'd6, 64'h50);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // AMOAdd wraps to zero, response is the old value.
        push(64'hFFFF_FFFF_FFFF_FFFF, 8'd1);
        send(32'h10, AMO_ADD, 1'b0, 64'd1, 8'd0, 8'd1);
        drain("drain_add");
        chk("mem_add_wrap", mem[2], 64'd0);

        // Load response appears the cycle after acceptance.
        push(64'd0, 8'd2);
        send(32'h10, AMO_NONE, 1'b0, '0, 8'd0, 8'd2);
        @(negedge clk);
        chk("load_latency", 64'(in_valid_o), 64'd1);
        @(posedge clk); #1;
        drain("drain_load");

        // Foreign store kills core 3's reservation.
        push(64'h1234, 8'd3);
        send(32'h40, AMO_LR, 1'b0, '0, 8'd3, 8'd3);
        send(32'h40, AMO_NONE, 1'b1, 64'hAAAA, 8'd5, 8'd4);
        push(64'd1, 8'd5);
        send(32'h40, AMO_SC, 1'b0, 64'h5555, 8'd3, 8'd5);
        drain("drain_sc_fail");
        chk("mem_sc_fail", mem[8], 64'hAAAA);

        // Clean LR/SC pair succeeds once; the repeat SC fails.
        push(64'hAAAA, 8'd6);
        send(32'h40, AMO_LR, 1'b0, '0, 8'd3, 8'd6);
        push(64'd0, 8'd7);
        send(32'h40, AMO_SC, 1'b0, 64'h77, 8'd3, 8'd7);
        push(64'd1, 8'd8);
        send(32'h40, AMO_SC, 1'b0, 64'h88, 8'd3, 8'd8);
        drain("drain_sc_ok");
        chk("mem_sc_ok", mem[8], 64'h77);

        // Two slots, three LRs: core 1 is evicted round-robin.
        push(64'h100, 8'd9);  send(32'h100, AMO_LR, 1'b0, '0, 8'd1, 8'd9);
        push(64'h200, 8'd10); send(32'h108, AMO_LR, 1'b0, '0, 8'd2, 8'd10);
        push(64'h300, 8'd11); send(32'h110, AMO_LR, 1'b0, '0, 8'd3, 8'd11);
        push(64'd1, 8'd12);   send(32'h100, AMO_SC, 1'b0, 64'hE1, 8'd1, 8'd12);
        push(64'd0, 8'd13);   send(32'h110, AMO_SC, 1'b0, 64'hE3, 8'd3, 8'd13);
        push(64'd0, 8'd14);   send(32'h108, AMO_SC, 1'b0, 64'hE2, 8'd2, 8'd14);
        drain("drain_evict");
        chk("mem_evict_c1", mem[8'h20], 64'h100);
        chk("mem_evict_c3", mem[8'h22], 64'hE3);
        chk("mem_evict_c2", mem[8'h21], 64'hE2);

        // Backpressure: third load waits for the first pop; order kept.
        in_ready_i = 1'b0;
        push(64'hA1, 8'd15); push(64'hB2, 8'd16); push(64'hC3, 8'd17);
        send(32'h50, AMO_NONE, 1'b0, '0, 8'd0, 8'd15);
        send(32'h58, AMO_NONE, 1'b0, '0, 8'd0, 8'd16);
        drive(32'h60, AMO_NONE, 1'b0, '0, 8'd0, 8'd17);
        @(negedge clk);
        chk("bp_stall", 64'(in_ready_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_stall_hold", 64'(in_ready_o), 64'd0);
        chk("bp_head_valid", 64'(in_valid_o), 64'd1);
        chk("bp_head_data", in_rdata_o, 64'hA1);
        @(posedge clk); #1;
        in_ready_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready_o) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("bp_release", 64'(ok), 64'd1);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        drain("drain_bp");

        // Registered AMO: busy for DoAMO and WriteBack.
        push(64'd3, 8'd18);
        send(32'h20, AMO_MAX, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 8'd0, 8'd18);
        @(negedge clk);
        chk("amo_busy1", 64'(in_ready_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("amo_busy2", 64'(in_ready_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("amo_free", 64'(in_ready_o), 64'd1);
        chk("mem_max", mem[4], 64'd3);
        @(posedge clk); #1;
        push(64'd3, 8'd19);
        send(32'h20, AMO_MAXU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 8'd0, 8'd19);
        drain("drain_maxu");
        chk("mem_maxu", mem[4], 64'hFFFF_FFFF_FFFF_FFFB);
        push(64'hFFFF_FFFF_FFFF_FFFB, 8'd20);
        send(32'h20, AMO_MINU, 1'b0, 64'd7, 8'd0, 8'd20);
        drain("drain_minu");
        chk("mem_minu", mem[4], 64'd7);
        push(64'd7, 8'd21);
        send(32'h20, AMO_MIN, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 8'd0, 8'd21);
        drain("drain_min");
        chk("mem_min", mem[4], 64'hFFFF_FFFF_FFFF_FFFB);

        // Reset during DoAMO: no write-back, no response.
        in_ready_i = 1'b0;
        send(32'h30, AMO_SWAP, 1'b0, 64'hDEAD, 8'd0, 8'd22);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("rst_amo_write", 64'(out_write_o), 64'd0);
        chk("rst_amo_valid", 64'(in_valid_o), 64'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        in_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_valid", 64'(in_valid_o), 64'd0);
        chk("post_rst_ready", 64'(in_ready_o), 64'd1);
        chk("mem_rst_amo", mem[6], 64'h50);
        @(posedge clk); #1;
        push(64'h50, 8'd23);
        send(32'h30, AMO_NONE, 1'b0, '0, 8'd0, 8'd23);
        drain("drain_post_rst");

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
